// File: rtl/guess_core.sv
// Number-guessing game core: BCD guess entry, digit-serial MSD-first compare,
// per-round timer and guess budget, multi-round win/lose tracking.
module guess_core #(
    parameter int MAX_DIGITS  = 3,
    parameter int GUESS_LIMIT = 5,
    parameter int NUM_ROUNDS  = 3,
    parameter int TIME_LIMIT  = 99,
    localparam int TW = $clog2(TIME_LIMIT + 1),
    localparam int GW = $clog2(GUESS_LIMIT + 1),
    localparam int RW = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    tick,
    input  logic                    inc,
    input  logic                    next,
    input  logic                    confirm,
    input  logic [2:0]              active_digits,
    input  logic [4*MAX_DIGITS-1:0] target,
    output logic [4*MAX_DIGITS-1:0] guess,
    output logic [2:0]              cursor,
    output logic [1:0]              hint,
    output logic [GW-1:0]           guesses_left,
    output logic [RW-1:0]           round,
    output logic [TW-1:0]           timer,
    output logic [1:0]              status,
    output logic                    busy
);

    typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_WIN, S_LOSE} state_t;

    state_t                  r_state,  w_stateNext;
    logic [2:0]              r_digits, w_digitsNext;
    logic [2:0]              r_cursor, w_cursorNext;
    logic [2:0]              r_idx,    w_idxNext;
    logic [4*MAX_DIGITS-1:0] r_target, w_targetNext;
    logic [4*MAX_DIGITS-1:0] r_guess,  w_guessNext;
    logic [1:0]              r_hint,   w_hintNext;
    logic [GW-1:0]           r_left,   w_leftNext;
    logic [RW-1:0]           r_round,  w_roundNext;
    logic [TW-1:0]           r_timer,  w_timerNext;

    logic [TW-1:0] w_timerDec;
    logic [GW-1:0] w_leftDec;
    logic [RW-1:0] w_roundInc;
    logic [3:0]    w_gDig, w_tDig, w_curDig;
    logic [2:0]    w_clamped;

    always_comb begin
        w_gDig     = r_guess[4*r_idx +: 4];
        w_tDig     = r_target[4*r_idx +: 4];
        w_curDig   = r_guess[4*r_cursor +: 4];
        w_timerDec = (tick && r_timer != '0) ? r_timer - TW'(1) : r_timer;
        w_leftDec  = r_left - GW'(1);
        w_roundInc = r_round + RW'(1);
        if (active_digits == 3'd0)
            w_clamped = 3'd1;
        else if (active_digits > 3'(MAX_DIGITS))
            w_clamped = 3'(MAX_DIGITS);
        else
            w_clamped = active_digits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_digits <= 3'd1;
            r_cursor <= '0;
            r_idx    <= '0;
            r_target <= '0;
            r_guess  <= '0;
            r_hint   <= 2'b00;
            r_left   <= GW'(GUESS_LIMIT);
            r_round  <= '0;
            r_timer  <= TW'(TIME_LIMIT);
        end else begin
            r_state  <= w_stateNext;
            r_digits <= w_digitsNext;
            r_cursor <= w_cursorNext;
            r_idx    <= w_idxNext;
            r_target <= w_targetNext;
            r_guess  <= w_guessNext;
            r_hint   <= w_hintNext;
            r_left   <= w_leftNext;
            r_round  <= w_roundNext;
            r_timer  <= w_timerNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_digitsNext = r_digits;
        w_cursorNext = r_cursor;
        w_idxNext    = r_idx;
        w_targetNext = r_target;
        w_guessNext  = r_guess;
        w_hintNext   = r_hint;
        w_leftNext   = r_left;
        w_roundNext  = r_round;
        w_timerNext  = r_timer;
        if (start) begin
            w_stateNext  = S_PLAY;
            w_digitsNext = w_clamped;
            w_targetNext = target;
            w_guessNext  = '0;
            w_cursorNext = '0;
            w_idxNext    = '0;
            w_hintNext   = 2'b00;
            w_leftNext   = GW'(GUESS_LIMIT);
            w_roundNext  = '0;
            w_timerNext  = TW'(TIME_LIMIT);
        end else begin
            case (r_state)
                S_PLAY: begin
                    w_timerNext = w_timerDec;
                    if (inc)
                        w_guessNext[4*r_cursor +: 4] = (w_curDig >= 4'd9) ? 4'd0 : w_curDig + 4'd1;
                    if (next)
                        w_cursorNext = (r_cursor == r_digits - 3'd1) ? 3'd0 : r_cursor + 3'd1;
                    if (w_timerDec == '0) begin
                        w_stateNext = S_LOSE;
                    end else if (confirm) begin
                        w_stateNext = S_CHECK;
                        w_idxNext   = r_digits - 3'd1;
                    end
                end
                // First differing digit (MSD first) decides; an all-equal guess beats timer expiry.
                S_CHECK: begin
                    w_timerNext = w_timerDec;
                    if (w_gDig != w_tDig) begin
                        w_hintNext  = (w_gDig < w_tDig) ? 2'b01 : 2'b10;
                        w_leftNext  = w_leftDec;
                        w_stateNext = (w_leftDec == '0 || w_timerDec == '0) ? S_LOSE : S_PLAY;
                    end else if (r_idx == 3'd0) begin
                        w_hintNext  = 2'b11;
                        w_roundNext = w_roundInc;
                        if (w_roundInc == RW'(NUM_ROUNDS)) begin
                            w_stateNext = S_WIN;
                        end else begin
                            w_stateNext  = S_PLAY;
                            w_targetNext = target;
                            w_guessNext  = '0;
                            w_cursorNext = '0;
                            w_leftNext   = GW'(GUESS_LIMIT);
                            w_timerNext  = TW'(TIME_LIMIT);
                        end
                    end else begin
                        w_idxNext = r_idx - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            S_PLAY, S_CHECK: status = 2'b01;
            S_WIN:           status = 2'b10;
            S_LOSE:          status = 2'b11;
            default:         status = 2'b00;
        endcase
    end

    assign busy         = (r_state == S_CHECK);
    assign guess        = r_guess;
    assign cursor       = r_cursor;
    assign hint         = r_hint;
    assign guesses_left = r_left;
    assign round        = r_round;
    assign timer        = r_timer;

endmodule

// File: tb/tb_guess_core.sv
// Directed bench for guess_core; confirm outcomes go through a scoreboard queue
// and are checked when busy falls.
module tb_guess_core;

    logic        clk = 0, rst = 0, start = 0, tick = 0, inc = 0, next = 0, confirm = 0;
    logic [2:0]  active_digits = 3'd3;
    logic [11:0] target = 12'h527;
    logic [11:0] guess;
    logic [2:0]  cursor;
    logic [1:0]  hint;
    logic [2:0]  guesses_left;
    logic [1:0]  round;
    logic [6:0]  timer;
    logic [1:0]  status;
    logic        busy;

    int total = 0, bad = 0;

    typedef struct {
        logic [1:0]  hint;
        logic [2:0]  left;
        logic [1:0]  round;
        logic [1:0]  status;
        logic [11:0] guess;
        logic [6:0]  timer;
        int          cycles;
    } exp_t;
    exp_t sb[$];

    logic [11:0] mGuess;
    int          mCursor, mD, mTimer;

    guess_core dut (.*);

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic i, input logic n, input logic c, input logic t);
        inc = i; next = n; confirm = c; tick = t;
        step();
        inc = 0; next = 0; confirm = 0; tick = 0;
    endtask

    task automatic doStart(input logic [2:0] ad, input logic [11:0] tg);
        active_digits = ad;
        target = tg;
        start = 1;
        step();
        start = 0;
        mGuess = '0;
        mCursor = 0;
        mTimer = 99;
        mD = (ad == 0) ? 1 : (ad > 3) ? 3 : int'(ad);
    endtask

    task automatic doInc();
        int d;
        applyStimulus(1, 0, 0, 0);
        d = int'(mGuess[4*mCursor +: 4]);
        mGuess[4*mCursor +: 4] = 4'((d + 1) % 10);
    endtask

    task automatic doNext();
        applyStimulus(0, 1, 0, 0);
        mCursor = (mCursor == mD - 1) ? 0 : mCursor + 1;
    endtask

    task automatic doTick();
        applyStimulus(0, 0, 0, 1);
        if (mTimer > 0) mTimer--;
    endtask

    task automatic enterGuess(input logic [11:0] g);
        for (int i = 0; i < mD; i++) begin
            int n;
            while (mCursor != i) doNext();
            n = (int'(g[4*i +: 4]) - int'(mGuess[4*i +: 4]) + 10) % 10;
            repeat (n) doInc();
        end
    endtask

    // Push the expected outcome, confirm, then wait (bounded) for busy to fall and compare.
    task automatic confirmExpect(input string tag, input exp_t e, input bit tickFirst);
        exp_t got;
        int   n = 0;
        sb.push_back(e);
        applyStimulus(0, 0, 1, 0);
        tick = tickFirst;
        while (busy === 1'b1 && n < 20) begin
            step();
            tick = 0;
            n++;
        end
        tick = 0;
        got = sb.pop_front();
        checkOutput({tag, ".busyCycles"}, n, got.cycles);
        checkOutput({tag, ".hint"}, hint, got.hint);
        checkOutput({tag, ".left"}, guesses_left, got.left);
        checkOutput({tag, ".round"}, round, got.round);
        checkOutput({tag, ".status"}, status, got.status);
        checkOutput({tag, ".guess"}, guess, got.guess);
        checkOutput({tag, ".timer"}, timer, got.timer);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".guess"}, guess, 0);
        checkOutput({tag, ".cursor"}, cursor, 0);
        checkOutput({tag, ".hint"}, hint, 0);
        checkOutput({tag, ".left"}, guesses_left, 5);
        checkOutput({tag, ".round"}, round, 0);
        checkOutput({tag, ".timer"}, timer, 99);
        checkOutput({tag, ".status"}, status, 0);
        checkOutput({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        #1 rst = 1;
        #3 checkResetValues("reset");
        step();
        rst = 0;
        applyStimulus(1, 1, 1, 1);
        step();
        checkResetValues("idleIgnore");

        doStart(3'd3, 12'h527);
        checkOutput("start.status", status, 1);
        checkOutput("start.left", guesses_left, 5);
        checkOutput("start.timer", timer, 99);
        enterGuess(12'h499);
        checkOutput("entry499", guess, 12'h499);
        confirmExpect("low499", '{2'b01, 3'd4, 2'd0, 2'b01, 12'h499, 7'd99, 1}, 0);

        enterGuess(12'h527);
        repeat (3) doTick();
        checkOutput("timerTicks", timer, 96);
        confirmExpect("eq527", '{2'b11, 3'd5, 2'd1, 2'b01, 12'h000, 7'd99, 3}, 0);
        checkOutput("eq527.cursor", cursor, 0);
        mGuess = '0; mCursor = 0; mTimer = 99;

        enterGuess(12'h529);
        for (int k = 1; k <= 5; k++)
            confirmExpect($sformatf("wrong%0d", k),
                          '{2'b10, 3'(5 - k), 2'd1, (k == 5) ? 2'b11 : 2'b01, 12'h529, 7'(mTimer), 3}, 0);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(1, 0, 1, 0);
        checkOutput("lose.guess", guess, 12'h529);
        checkOutput("lose.hint", hint, 2'b10);
        checkOutput("lose.left", guesses_left, 0);
        checkOutput("lose.timer", timer, mTimer);
        checkOutput("lose.status", status, 2'b11);
        checkOutput("lose.cursor", cursor, mCursor);

        doStart(3'd0, 12'h527);
        doNext();
        checkOutput("d1.cursor", cursor, 0);
        repeat (3) doInc();
        checkOutput("d1.inc3", guess, 12'h003);
        repeat (7) doInc();
        checkOutput("d1.wrap", guess, 12'h000);
        enterGuess(12'h007);
        confirmExpect("d1.eq", '{2'b11, 3'd5, 2'd1, 2'b01, 12'h000, 7'd99, 1}, 0);

        doStart(3'd7, 12'h527);
        doNext(); checkOutput("d3.cur1", cursor, 1);
        doNext(); checkOutput("d3.cur2", cursor, 2);
        doNext(); checkOutput("d3.cur0", cursor, 0);

        doStart(3'd3, 12'h527);
        enterGuess(12'h527);
        repeat (98) doTick();
        checkOutput("expEq.timer1", timer, 1);
        confirmExpect("expEq", '{2'b11, 3'd5, 2'd1, 2'b01, 12'h000, 7'd99, 3}, 1);

        doStart(3'd3, 12'h527);
        enterGuess(12'h529);
        repeat (98) doTick();
        confirmExpect("expWrong", '{2'b10, 3'd4, 2'd0, 2'b11, 12'h529, 7'd0, 3}, 1);

        doStart(3'd3, 12'h527);
        enterGuess(12'h527);
        applyStimulus(0, 0, 1, 0);
        checkOutput("abort.busy1", busy, 1);
        step();
        checkOutput("abort.busy2", busy, 1);
        rst = 1;
        #1 checkResetValues("abort");
        step();
        rst = 0;
        repeat (4) step();
        checkOutput("abort.hintAfter", hint, 0);
        checkOutput("abort.idleAfter", status, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
